// File: rtl/qs_pkg.sv
// Shared quicksort package: stack opcodes and the default index/count widths
// used by the multi-context pending-range stack.
package qs_pkg;

    localparam int QS_N    = 16;
    localparam int QS_C    = 4;
    localparam int QS_W    = 32;
    localparam int QS_CW   = (QS_C > 1) ? $clog2(QS_C) : 1;
    localparam int QS_IW   = $clog2(QS_N);
    localparam int QS_CNTW = $clog2(QS_N + 1);

    typedef enum logic [1:0] {
        PUSH = 2'd0,
        POP  = 2'd1,
        PEEK = 2'd2,
        CLR  = 2'd3
    } qs_stk_op_t;

    typedef logic [QS_CW-1:0]   qs_ctx_t;
    typedef logic [QS_IW-1:0]   qs_idx_t;
    typedef logic [QS_CNTW-1:0] qs_cnt_t;

endpackage

// File: rtl/spsram.sv
// Single-port synchronous RAM with registered read; a write cycle leaves the
// read register untouched.
module spsram #(
    parameter  int W     = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/qs_srt_mstack.sv
// C independent LIFO stacks of depth N sharing one single-port SRAM; POP/PEEK
// data returns two cycles later as a registered head word tagged with its context.
module qs_srt_mstack
    import qs_pkg::*;
#(
    parameter  int N  = 16,
    parameter  int W  = 32,
    parameter  int C  = 4,
    localparam int CW = (C > 1) ? $clog2(C) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_vld_r,
    input  logic [1:0]    cmd_op_r,
    input  logic [CW-1:0] cmd_ctx_r,
    input  logic [W-1:0]  cmd_dat_r,
    output logic          cmd_err_w,
    output logic [W-1:0]  head_r,
    output logic [CW-1:0] head_ctx_r,
    output logic          head_vld_r,
    output logic [C-1:0]  empty_w,
    output logic [C-1:0]  full_w
);

    localparam int IW   = $clog2(N);
    localparam int CNTW = $clog2(N + 1);
    localparam int AW   = $clog2(C * N);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(N);

    qs_stk_op_t      w_op;
    logic [CNTW-1:0] w_cnt_all [C];
    logic [CNTW-1:0] w_cur_cnt;
    logic            w_err;
    logic            w_acc;
    logic            w_push;
    logic            w_rd;
    logic [IW-1:0]   w_idx;
    logic [AW-1:0]   w_addr;
    logic [W-1:0]    w_rdata;
    logic            r_rd_vld;
    logic [CW-1:0]   r_rd_ctx;

    assign w_op      = qs_stk_op_t'(cmd_op_r);
    assign w_cur_cnt = w_cnt_all[cmd_ctx_r];

    always_comb begin
        w_err = 1'b0;
        if (cmd_vld_r) begin
            case (w_op)
                PUSH:      w_err = (w_cur_cnt == FULL_CNT);
                POP, PEEK: w_err = (w_cur_cnt == '0);
                default:   w_err = 1'b0;
            endcase
        end
    end

    assign cmd_err_w = w_err;
    assign w_acc     = cmd_vld_r && !w_err;
    assign w_push    = w_acc && (w_op == PUSH);
    assign w_rd      = w_acc && ((w_op == POP) || (w_op == PEEK));

    // Push writes the slot just above the top; reads address the current top.
    assign w_idx = w_push ? w_cur_cnt[IW-1:0] : IW'(w_cur_cnt - CNTW'(1));

    generate
        if (C > 1) begin : g_addr_ctx
            assign w_addr = {cmd_ctx_r, w_idx};
        end else begin : g_addr_flat
            assign w_addr = w_idx;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < C; gi++) begin : g_ctx
            logic            w_sel;
            logic [CNTW-1:0] w_cnt_next;
            logic [CNTW-1:0] r_cnt;

            assign w_sel = w_acc && (cmd_ctx_r == CW'(gi));

            always_comb begin
                w_cnt_next = r_cnt;
                if (w_sel) begin
                    case (w_op)
                        PUSH:    w_cnt_next = r_cnt + CNTW'(1);
                        POP:     w_cnt_next = r_cnt - CNTW'(1);
                        CLR:     w_cnt_next = '0;
                        default: w_cnt_next = r_cnt;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_sel) begin
                    r_cnt <= w_cnt_next;
                end
            end

            assign w_cnt_all[gi] = r_cnt;
            assign empty_w[gi]   = (w_cnt_next == '0);
            assign full_w[gi]    = (w_cnt_next == FULL_CNT);
        end
    endgenerate

    spsram #(
        .W     (W),
        .DEPTH (C * N)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_push || w_rd),
        .i_we    (w_push),
        .i_addr  (w_addr),
        .i_wdata (cmd_dat_r),
        .o_rdata (w_rdata)
    );

    // Only the valid bits are reset so a read in flight at reset never surfaces.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld   <= 1'b0;
            head_vld_r <= 1'b0;
        end else begin
            r_rd_vld   <= w_rd;
            head_vld_r <= r_rd_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd) begin
            r_rd_ctx <= cmd_ctx_r;
        end
        if (r_rd_vld) begin
            head_r     <= w_rdata;
            head_ctx_r <= r_rd_ctx;
        end
    end

endmodule

// File: tb/tb_qs_srt_mstack.sv
// Randomised and directed bench for qs_srt_mstack against a queue-per-context
// reference model with a cycle-slotted expected-head schedule.
module tb_qs_srt_mstack;

    localparam int N = 16;
    localparam int W = 32;
    localparam int C = 4;
    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_PEEK = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_vld_r = 1'b0;
    logic [1:0]   cmd_op_r = 2'd0;
    logic [1:0]   cmd_ctx_r = 2'd0;
    logic [W-1:0] cmd_dat_r = '0;
    logic         cmd_err_w;
    logic [W-1:0] head_r;
    logic [1:0]   head_ctx_r;
    logic         head_vld_r;
    logic [C-1:0] empty_w;
    logic [C-1:0] full_w;

    qs_srt_mstack #(.N(N), .W(W), .C(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_vld_r  (cmd_vld_r),
        .cmd_op_r   (cmd_op_r),
        .cmd_ctx_r  (cmd_ctx_r),
        .cmd_dat_r  (cmd_dat_r),
        .cmd_err_w  (cmd_err_w),
        .head_r     (head_r),
        .head_ctx_r (head_ctx_r),
        .head_vld_r (head_vld_r),
        .empty_w    (empty_w),
        .full_w     (full_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one queue per context; expected heads scheduled by cycle.
    logic [W-1:0] mq [C][$];
    logic         sv [8];
    logic [W-1:0] sd [8];
    logic [1:0]   sc [8];
    logic         exp_err;
    logic [C-1:0] exp_empty;
    logic [C-1:0] exp_full;
    bit           st_vld = 1'b0;
    bit           mon_en = 1'b0;

    always @(negedge clk) begin
        hs = cyc % 8;
        if (mon_en) begin
            checks++;
            if (head_vld_r !== sv[hs]) begin
                failures++;
                $display("FAIL head_vld cyc=%0d got=%b exp=%b", cyc, head_vld_r, sv[hs]);
            end else if (sv[hs] && (head_r !== sd[hs] || head_ctx_r !== sc[hs])) begin
                failures++;
                $display("FAIL head_data cyc=%0d got=%h/ctx%0d exp=%h/ctx%0d",
                         cyc, head_r, head_ctx_r, sd[hs], sc[hs]);
            end
        end
        sv[hs] = 1'b0;
    end

    always @(negedge clk) begin
        #2;
        if (st_vld) begin
            checks++;
            if ({cmd_err_w, empty_w, full_w} !== {exp_err, exp_empty, exp_full}) begin
                failures++;
                $display("FAIL status cyc=%0d got err=%b empty=%b full=%b exp err=%b empty=%b full=%b",
                         cyc, cmd_err_w, empty_w, full_w, exp_err, exp_empty, exp_full);
            end
            st_vld = 1'b0;
        end
    end

    task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] ctx,
                         input logic [W-1:0] d);
        logic         hv;
        logic [W-1:0] hd;
        int           s;
        @(negedge clk);
        cmd_vld_r = v;
        cmd_op_r  = op;
        cmd_ctx_r = ctx;
        cmd_dat_r = d;
        exp_err = 1'b0;
        hv = 1'b0;
        hd = '0;
        if (v) begin
            case (op)
                OP_PUSH: if (mq[ctx].size() >= N) exp_err = 1'b1; else mq[ctx].push_back(d);
                OP_POP:  if (mq[ctx].size() == 0) exp_err = 1'b1;
                         else begin hd = mq[ctx].pop_back(); hv = 1'b1; end
                OP_PEEK: if (mq[ctx].size() == 0) exp_err = 1'b1;
                         else begin hd = mq[ctx][$]; hv = 1'b1; end
                default: mq[ctx].delete();
            endcase
        end
        if (hv) begin
            s = (cyc + 2) % 8;
            sv[s] = 1'b1;
            sd[s] = hd;
            sc[s] = ctx;
        end
        for (int c = 0; c < C; c++) begin
            exp_empty[c] = (mq[c].size() == 0);
            exp_full[c]  = (mq[c].size() == N);
        end
        st_vld = !rst;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, OP_PUSH, 2'd0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cmd_vld_r = 1'b0;
        for (int i = 1; i < 8; i++) sv[(cyc + i) % 8] = 1'b0;
        for (int c = 0; c < C; c++) mq[c].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        mon_en = 1'b1;
        #1;
        checks++;
        if (empty_w !== 4'hF || full_w !== 4'h0) begin
            failures++;
            $display("FAIL reset_status got empty=%b full=%b exp empty=1111 full=0000", empty_w, full_w);
        end
        drive(1'b1, OP_POP, 2'd0, '0);
        #1;
        checks++;
        if (cmd_err_w !== 1'b1) begin
            failures++;
            $display("FAIL reset_pop_err got=%b exp=1", cmd_err_w);
        end
        idle(3);
    endtask

    task automatic test_lifo();
        drive(1'b1, OP_PUSH, 2'd1, 32'hA);
        drive(1'b1, OP_PUSH, 2'd1, 32'hB);
        drive(1'b1, OP_PUSH, 2'd1, 32'hC);
        repeat (3) drive(1'b1, OP_POP, 2'd1, '0);
        idle(3);
        #1;
        checks++;
        if (head_r !== 32'hA || head_ctx_r !== 2'd1 || empty_w[1] !== 1'b1) begin
            failures++;
            $display("FAIL lifo_hold got head=%h ctx=%0d empty1=%b exp head=0000000a ctx=1 empty1=1",
                     head_r, head_ctx_r, empty_w[1]);
        end
    endtask

    task automatic test_full();
        logic [W-1:0] last;
        last = '0;
        for (int i = 0; i < N; i++) begin
            last = $urandom;
            drive(1'b1, OP_PUSH, 2'd2, last);
        end
        #1;
        checks++;
        if (full_w[2] !== 1'b1) begin
            failures++;
            $display("FAIL full_flag got=%b exp=1", full_w[2]);
        end
        drive(1'b1, OP_PUSH, 2'd2, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (cmd_err_w !== 1'b1) begin
            failures++;
            $display("FAIL overflow_err got=%b exp=1", cmd_err_w);
        end
        drive(1'b1, OP_POP, 2'd2, '0);
        idle(3);
        #1;
        checks++;
        if (head_r !== last) begin
            failures++;
            $display("FAIL full_last got=%h exp=%h", head_r, last);
        end
    endtask

    task automatic test_interleave();
        do_reset();
        drive(1'b1, OP_PUSH, 2'd0, 32'h11);
        drive(1'b1, OP_PUSH, 2'd3, 32'h22);
        drive(1'b1, OP_POP, 2'd0, '0);
        drive(1'b1, OP_POP, 2'd3, '0);
        idle(3);
        #1;
        checks++;
        if (empty_w !== 4'hF) begin
            failures++;
            $display("FAIL interleave_empty got=%b exp=1111", empty_w);
        end
    endtask

    task automatic test_peek();
        drive(1'b1, OP_PUSH, 2'd1, 32'h5);
        drive(1'b1, OP_PEEK, 2'd1, '0);
        #1;
        checks++;
        if (empty_w[1] !== 1'b0) begin
            failures++;
            $display("FAIL peek_keeps got empty1=%b exp=0", empty_w[1]);
        end
        drive(1'b1, OP_PEEK, 2'd1, '0);
        drive(1'b1, OP_POP, 2'd1, '0);
        #1;
        checks++;
        if (empty_w[1] !== 1'b1) begin
            failures++;
            $display("FAIL pop_empties got empty1=%b exp=1", empty_w[1]);
        end
        idle(3);
    endtask

    task automatic test_clr();
        for (int i = 0; i < 3; i++) drive(1'b1, OP_PUSH, 2'd0, 32'h100 + i);
        drive(1'b1, OP_CLR, 2'd0, '0);
        #1;
        checks++;
        if (empty_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL clr_empty got=%b exp=1", empty_w[0]);
        end
        drive(1'b1, OP_PUSH, 2'd0, 32'h7);
        drive(1'b1, OP_POP, 2'd0, '0);
        drive(1'b1, OP_POP, 2'd0, '0);
        #1;
        checks++;
        if (cmd_err_w !== 1'b1) begin
            failures++;
            $display("FAIL clr_stale_pop got err=%b exp=1", cmd_err_w);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, OP_PUSH, 2'd3, 32'hCAFE_0001);
        drive(1'b1, OP_POP,  2'd3, '0);
        drive(1'b1, OP_PUSH, 2'd3, 32'hCAFE_0002);
        drive(1'b1, OP_PEEK, 2'd3, '0);
        drive(1'b1, OP_PUSH, 2'd0, 32'hBEEF_0003);
        drive(1'b1, OP_POP,  2'd3, '0);
        drive(1'b1, OP_POP,  2'd0, '0);
        idle(3);
    endtask

    task automatic test_reset_mid();
        bit seen;
        drive(1'b1, OP_PUSH, 2'd2, 32'h9);
        drive(1'b1, OP_POP,  2'd2, '0);
        @(negedge clk);
        rst = 1'b1;
        cmd_vld_r = 1'b0;
        for (int i = 1; i < 8; i++) sv[(cyc + i) % 8] = 1'b0;
        for (int c = 0; c < C; c++) mq[c].delete();
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (head_vld_r) seen = 1'b1;
        end
        rst = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_pulse got=%b exp=0", seen);
        end
        idle(2);
    endtask

    task automatic test_random();
        int r;
        logic [1:0] op;
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? OP_PUSH : (r < 7) ? OP_POP : (r < 9) ? OP_PEEK : OP_CLR;
            drive($urandom_range(0, 7) != 0, op, 2'($urandom_range(0, 3)), $urandom);
        end
        idle(4);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) sv[i] = 1'b0;
        test_reset();
        test_lifo();
        test_full();
        test_interleave();
        test_peek();
        test_clr();
        test_back_to_back();
        test_reset_mid();
        test_random();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
